// File: rtl/bcedn_adapter_mc.sv
// bcedn_adapter_mc: streaming 3x3 binary convolution adapter (stride 1, zero pad 1).
// Pixels arrive in raster order. For each output position the block runs FD/N_PE
// compute cycles, N_PE filters per cycle, and then presents an FD-bit binary
// feature vector with a valid/ready handshake. Filter 0 is the MSB of data_out.
//
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   start           frame start pulse (honoured only in IDLE)
//   in_valid/in_ready/data_in    pixel stream, channel 0 in MSBs
//   out_valid/out_ready/data_out feature vector stream
//   busy, done      frame in progress / one-cycle end-of-frame pulse
//   wl_en/wl_addr/wl_data        per-filter weight load {weights, ref, sign}
//
// Optional feature: define BCEDN_ADAPTER_WLOAD_EN to enable writes through the
// wl_* port while IDLE. Otherwise the wl_* port is present but ignored.
//
// Weight word layout (MSB first): tap t=(dr+1)*3+(dc+1), channel ch, entry
// index t*D+ch with index 0 in the MSBs. The reference holds DATA_FRAC fraction
// bits and is shifted up to the accumulator fraction before comparison.
module bcedn_adapter_mc #(
    parameter int unsigned H            = 32,
    parameter int unsigned W            = 128,
    parameter int unsigned D            = 1,
    parameter int unsigned FD           = 128,
    parameter int unsigned N_PE         = 1,
    parameter int unsigned DATA_W       = 17,
    parameter int unsigned DATA_FRAC    = 8,
    parameter int unsigned WEIGHT_W     = 17,
    parameter int unsigned WEIGHT_FRAC  = 8,
    parameter int unsigned NORMREF_W    = 15,
    parameter string       W_MEM_NAME   = "",
    parameter string       REF_MEM_NAME = ""
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [D*DATA_W-1:0]                 data_in,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [FD-1:0]                       data_out,
    output logic                                busy,
    output logic                                done,
    input  logic                                wl_en,
    input  logic [$clog2(FD)-1:0]               wl_addr,
    input  logic [9*D*WEIGHT_W+NORMREF_W+1-1:0] wl_data
);

    localparam int unsigned WGT_BITS  = 9 * D * WEIGHT_W;
    localparam int unsigned REF_BITS  = NORMREF_W + 1;
    localparam int unsigned NPIX      = H * W;
    localparam int unsigned NK        = FD / N_PE;
    localparam int unsigned PW        = DATA_W + WEIGHT_W;
    localparam int unsigned AW        = PW + $clog2(9 * D);
    localparam int unsigned REF_FRAC  = DATA_FRAC;
    localparam int unsigned REF_SHIFT = DATA_FRAC + WEIGHT_FRAC - REF_FRAC;
    localparam int unsigned SR_LEN    = 2 * W + 3;
    localparam int unsigned SR_AW     = $clog2(SR_LEN);
    localparam int unsigned PCW       = $clog2(NPIX + 1);
    localparam int unsigned RW        = (H > 1) ? $clog2(H) : 1;
    localparam int unsigned CW        = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned KW        = (NK > 1) ? $clog2(NK) : 1;
    localparam int unsigned FA        = (FD > 1) ? $clog2(FD) : 1;

    typedef enum logic [1:0] {IDLE, FILL, COMPUTE, EMIT} state_t;

    state_t                state, state_n;
    logic [PCW-1:0]        pix_cnt, pix_cnt_n;
    logic [RW-1:0]         row, row_n;
    logic [CW-1:0]         col, col_n;
    logic [KW-1:0]         k, k_n;
    logic [D*DATA_W-1:0]   sr [SR_LEN];
    logic                  out_valid_n, busy_n, done_n;
    logic [FD-1:0]         data_out_n;
    logic [N_PE-1:0]       bits_c;
    logic                  accept_c, trig_c, last_c;
    logic signed [DATA_W-1:0] tap_c [9][D];

    logic [WGT_BITS-1:0]   wmem [FD];
    logic [REF_BITS-1:0]   rmem [FD];

    // Index of the newest pixel needed by output (r,c); the whole frame for the last row.
    function automatic int ptr_f(input int r, input int c);
        if (r < int'(H) - 1)
            return (r + 1) * int'(W) + ((c + 1 < int'(W)) ? c + 1 : int'(W) - 1);
        return int'(NPIX) - 1;
    endfunction

`ifdef BCEDN_ADAPTER_WLOAD_EN
    // Weight load, only while IDLE so a running frame never sees a change.
    always_ff @(posedge clk) begin
        if (wl_en && state == IDLE) begin
            wmem[wl_addr] <= wl_data[REF_BITS +: WGT_BITS];
            rmem[wl_addr] <= wl_data[REF_BITS-1:0];
        end
    end
`else
    logic unused_wl;
    assign unused_wl = ^{wl_en, wl_addr, wl_data};
`endif

    // Intake stops as soon as the current output's window is complete, so the
    // newest pixel in the shift register is always exactly ptr_f(row, col).
    assign trig_c   = int'(pix_cnt) > ptr_f(int'(row), int'(col));
    assign last_c   = (int'(row) == int'(H) - 1) && (int'(col) == int'(W) - 1);
    assign in_ready = (state == FILL) && (int'(pix_cnt) < int'(NPIX)) && !trig_c;
    assign accept_c = in_valid && in_ready;

    // Window extraction: tap pixel q sits at sr[ptr - q]; out-of-frame taps are zero.
    always_comb begin
        int r, c, p, rr, cc, off;
        r   = int'(row);
        c   = int'(col);
        p   = ptr_f(r, c);
        rr  = 0;
        cc  = 0;
        off = 0;
        for (int t = 0; t < 9; t++) begin
            rr  = r + t / 3 - 1;
            cc  = c + t % 3 - 1;
            off = p - (rr * int'(W) + cc);
            for (int ch = 0; ch < int'(D); ch++) begin
                tap_c[t][ch] = '0;
                if (rr >= 0 && rr < int'(H) && cc >= 0 && cc < int'(W))
                    tap_c[t][ch] = sr[SR_AW'(off)][(int'(D) - 1 - ch) * int'(DATA_W) +: DATA_W];
            end
        end
    end

    // One processing element per filter evaluated in a compute cycle.
    for (genvar j = 0; j < N_PE; j++) begin : g_pe
        logic [FA-1:0]            fidx_c;
        logic [WGT_BITS-1:0]      wword_c;
        logic [REF_BITS-1:0]      rword_c;
        logic signed [WEIGHT_W-1:0] w_c;
        logic signed [AW-1:0]     acc_c;
        logic signed [AW-1:0]     ref_c;

        assign fidx_c  = FA'(int'(k) * int'(N_PE) + j);
        assign wword_c = wmem[fidx_c];
        assign rword_c = rmem[fidx_c];
        assign ref_c   = AW'($signed(rword_c[REF_BITS-1:1])) <<< REF_SHIFT;

        always_comb begin
            acc_c = '0;
            w_c   = '0;
            for (int t = 0; t < 9; t++) begin
                for (int ch = 0; ch < int'(D); ch++) begin
                    w_c   = wword_c[(9 * int'(D) - 1 - (t * int'(D) + ch)) * int'(WEIGHT_W) +: WEIGHT_W];
                    acc_c = acc_c + AW'(PW'(tap_c[t][ch]) * PW'(w_c));
                end
            end
        end

        // Sign bit selects the comparison direction.
        assign bits_c[j] = rword_c[0] ? (acc_c <= ref_c) : (acc_c >= ref_c);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_n     = state;
        pix_cnt_n   = pix_cnt;
        row_n       = row;
        col_n       = col;
        k_n         = k;
        out_valid_n = out_valid;
        busy_n      = busy;
        done_n      = 1'b0;
        data_out_n  = data_out;
        if (accept_c)
            pix_cnt_n = pix_cnt + PCW'(1);
        case (state)
            IDLE: begin
                busy_n = start;
                if (start) begin
                    state_n   = FILL;
                    pix_cnt_n = '0;
                    row_n     = '0;
                    col_n     = '0;
                end
            end
            FILL: begin
                if (trig_c) begin
                    state_n = COMPUTE;
                    k_n     = '0;
                end
            end
            COMPUTE: begin
                for (int j = 0; j < int'(N_PE); j++)
                    data_out_n[FA'(int'(FD) - 1 - (int'(k) * int'(N_PE) + j))] = bits_c[j];
                k_n = k + KW'(1);
                if (int'(k) == int'(NK) - 1) begin
                    state_n     = EMIT;
                    out_valid_n = 1'b1;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    out_valid_n = 1'b0;
                    if (last_c) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        if (int'(col) == int'(W) - 1) begin
                            col_n = '0;
                            row_n = row + RW'(1);
                        end else begin
                            col_n = col + CW'(1);
                        end
                        k_n     = '0;
                        state_n = (int'(pix_cnt) > ptr_f(int'(row_n), int'(col_n))) ? COMPUTE : FILL;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, counters, line buffer and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            pix_cnt   <= '0;
            row       <= '0;
            col       <= '0;
            k         <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            data_out  <= '0;
            for (int i = 0; i < int'(SR_LEN); i++)
                sr[i] <= '0;
        end else begin
            state     <= state_n;
            pix_cnt   <= pix_cnt_n;
            row       <= row_n;
            col       <= col_n;
            k         <= k_n;
            out_valid <= out_valid_n;
            busy      <= busy_n;
            done      <= done_n;
            data_out  <= data_out_n;
            if (accept_c) begin
                sr[0] <= data_in;
                for (int i = 1; i < int'(SR_LEN); i++)
                    sr[i] <= sr[i-1];
            end
        end
    end

endmodule

// File: tb/tb_bcedn_adapter_mc.sv
// Directed bench for bcedn_adapter_mc with H=4, W=4, D=1, FD=4, N_PE=2.
// Expected feature vectors are queued at frame start and popped on each
// output handshake.
module tb_bcedn_adapter_mc;

    localparam int H         = 4;
    localparam int W         = 4;
    localparam int D         = 1;
    localparam int FD        = 4;
    localparam int N_PE      = 2;
    localparam int DATA_W    = 17;
    localparam int WEIGHT_W  = 17;
    localparam int NORMREF_W = 15;
    localparam int WL_W      = 9 * D * WEIGHT_W + NORMREF_W + 1;
    localparam logic [DATA_W-1:0] PIX_ONE = 17'd256;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic                 in_valid;
    logic                 in_ready;
    logic [D*DATA_W-1:0]  data_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [FD-1:0]        data_out;
    logic                 busy;
    logic                 done;
    logic                 wl_en;
    logic [1:0]           wl_addr;
    logic [WL_W-1:0]      wl_data;

    int checks   = 0;
    int failures = 0;
    logic [FD-1:0] expq [$];

    bcedn_adapter_mc #(
        .H(H), .W(W), .D(D), .FD(FD), .N_PE(N_PE),
        .DATA_W(DATA_W), .DATA_FRAC(8), .WEIGHT_W(WEIGHT_W), .WEIGHT_FRAC(8),
        .NORMREF_W(NORMREF_W), .W_MEM_NAME(""), .REF_MEM_NAME("")
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .busy(busy), .done(done),
        .wl_en(wl_en), .wl_addr(wl_addr), .wl_data(wl_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every filter: all nine weights 1.0, ref 5.0; filter 3 optionally with sign=1.
    task automatic load_coeffs(input logic sign3);
        logic [WL_W-1:0] word;
        for (int f = 0; f < FD; f++) begin
            word = {{9{17'd256}}, 15'd1280, (f == 3) ? sign3 : 1'b0};
`ifdef BCEDN_ADAPTER_WLOAD_EN
            wl_en   = 1'b1;
            wl_addr = 2'(f);
            wl_data = word;
            @(negedge clk);
`else
            dut.wmem[f] = word[WL_W-1:NORMREF_W+1];
            dut.rmem[f] = word[NORMREF_W:0];
`endif
        end
        wl_en = 1'b0;
        @(negedge clk);
    endtask

    // Runs one frame from IDLE. stall: cycles of out_ready low at the first output.
    // abort_after: pulse reset once that many pixels are in (0 = never).
    // restart_at: loop cycle at which start is pulsed again (-1 = never).
    task automatic run_frame(input int stall, input int abort_after, input int restart_at,
                             input logic [FD-1:0] ec, input logic [FD-1:0] eo);
        int cyc, hs, outs, hs5, stall_left;
        bit seen, fin;
        logic [FD-1:0] e;
        expq.delete();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                expq.push_back(((r == 0 || r == H - 1) && (c == 0 || c == W - 1)) ? ec : eo);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        cyc = 0; hs = 0; outs = 0; hs5 = -1; stall_left = 0; seen = 0; fin = 0;
        while (!fin && cyc < 1000) begin
            if (abort_after > 0 && hs == abort_after) begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
                rst       = 1'b0;
                @(negedge clk);
                chk("abort_in_ready", in_ready, 0);
                chk("abort_out_valid", out_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                chk("abort_data_out", data_out, 0);
                rst = 1'b1;
                @(negedge clk);
                return;
            end
            start    = (cyc == restart_at);
            in_valid = 1'b1;
            data_in  = (hs < H * W) ? PIX_ONE : 17'h1F0F0;
            if (out_valid && !seen) begin
                seen       = 1;
                stall_left = stall;
                chk("first_out_latency", 64'(cyc - hs5), 4);
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
                chk("stall_out_valid", out_valid, 1);
                chk("stall_data_out", data_out, expq[0]);
                chk("stall_in_ready", in_ready, 0);
            end else begin
                out_ready = 1'b1;
            end
            if (in_valid && in_ready) begin
                if (hs == 5) hs5 = cyc;
                hs++;
            end
            if (out_valid && out_ready) begin
                e = expq.pop_front();
                chk($sformatf("out%0d", outs), data_out, e);
                outs++;
                if (outs == H * W) fin = 1;
            end
            @(negedge clk);
            cyc++;
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("frame_complete", fin, 1);
        chk("done_pulse", done, 1);
        chk("busy_in_done_cycle", busy, 1);
        @(negedge clk);
        chk("done_low", done, 0);
        chk("busy_low", busy, 0);
        chk("pixels_taken", 64'(hs), 16);
        chk("queue_empty", 64'(expq.size()), 0);
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        data_in   = '0;
        out_ready = 1'b0;
        wl_en     = 1'b0;
        wl_addr   = '0;
        wl_data   = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_data_out", data_out, 0);
        rst = 1'b1;
        @(negedge clk);

        load_coeffs(1'b0);
        // Baseline frame with a 10-cycle consumer stall at the first output.
        run_frame(10, 0, -1, 4'h0, 4'hF);
        // Reset after 7 pixels, then a clean frame with the retained coefficients.
        run_frame(0, 7, -1, 4'h0, 4'hF);
        run_frame(0, 0, -1, 4'h0, 4'hF);
        // Spurious start mid-frame while in_valid stays high throughout.
        run_frame(0, 0, 12, 4'h0, 4'hF);
        // Filter 3 inverted comparison.
        load_coeffs(1'b1);
        run_frame(0, 0, -1, 4'h1, 4'hE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
